sd_block_responder: RTL
=======================

# sd_block_responder

Simulation and FPGA-loopback responder for the SD SPI host byte handshake: it plays the host side that an autotest initiator drives. It answers reset, block-read, byte-read, block-write and byte-write requests with `busy` handshakes and serves bytes from an internal block store. The autotest FSM and sdspi system tests can then run without a physical card.

## Interface

**Parameters**
- NUM_BLOCKS, 4: blocks held in the store, 512 bytes each.
- BASE_ADDR, 32'h0010_0000: card block address mapped to store block 0.
- INIT_CYCLES, 16: `busy` length after `rst_req`.
- BLOCK_LAT, 8: `busy` length when opening a block.
- BYTE_LAT, 2: `busy` length per byte transfer, minimum 2.

**Ports**
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- rst_req  in  1  card init request (level).
- block_addr  in  32  card block address, sampled on block open.
- r_block  in  1  read-block request, held for the whole block.
- r_byte  in  1  next-byte read request.
- w_block  in  1  write-block request, held for the whole block.
- w_byte  in  1  next-byte write request.
- data_in  in  8  write byte.
- data_out  out  8  last byte read.
- busy  out  1  operation in progress.
- err  out  1  address or sequence error.
- crc_err  out  1  write CRC mismatch; tied 0 unless the CRC check is compiled in.

## Operation

**Store:** NUM_BLOCKS×512 bytes of synchronous RAM. Block index = block_addr − BASE_ADDR (32-bit wrap). Addresses with index ≥ NUM_BLOCKS are out of range.

**State machine:** IDLE, INIT, OPEN, RD_READY, RD_BYTE, WR_READY, WR_BYTE.

- **IDLE**
  - rst_req=1 → INIT. This has priority over all other requests.
  - Otherwise, if initialized and r_block=1 or w_block=1 → OPEN. block_addr and the direction are latched. r_block wins if both are high.
  - If not initialized, a block request sets err=1 and the FSM stays in IDLE.
- **INIT**
  - busy=1 for INIT_CYCLES cycles.
  - Sets the initialized flag, clears err and crc_err, → IDLE.
- **OPEN**
  - busy=1 for BLOCK_LAT cycles.
  - Byte pointer cleared, data_out=8'hFF.
  - err is set if the address is out of range, cleared if in range.
  - → RD_READY (read) or WR_READY (write).
- **RD_READY**
  - busy=0.
  - r_block=0 → IDLE.
  - r_byte=1 → RD_BYTE.
- **RD_BYTE**
  - busy=1 for BYTE_LAT cycles.
  - On the last cycle: data_out = store[index][ptr], or 8'hFF if ptr≥512 or the address is out of range.
  - Pointer increments and saturates at 1023. → RD_READY.
- **WR_READY**
  - busy=0.
  - w_block=0 → IDLE.
  - w_byte=1 → WR_BYTE.
- **WR_BYTE**
  - busy=1 for BYTE_LAT cycles.
  - data_in is sampled on the last busy cycle. It is written to the store only if ptr<512 and the address is in range.
  - Bytes at ptr≥512 are discarded without error. They are used only by the CRC option.
  - Pointer increments. → RD_READY/WR_READY per the latched direction, i.e. WR_READY.

**Sequence rules**
- Requests are level-sensitive. r_byte or w_byte still high on return to a READY state starts another byte.
- w_byte in a read block, or r_byte in a write block, sets err=1 and is ignored.
- rst_req=1 in any non-IDLE state aborts the operation next cycle → INIT. Partially written bytes already stored remain.
- Dropping r_block or w_block mid-byte is ignored until the FSM returns to the READY state.

## Timing
- Reset values: data_out=8'hFF, busy=0, err=0, crc_err=0, FSM=IDLE, uninitialized. Store contents are not reset.
- busy rises on the clock edge after the request is seen in IDLE or READY. It stays high for exactly the stated length, then falls.
- data_out changes on the same edge that busy falls, and is stable until the next RD_BYTE completes.
- One byte costs BYTE_LAT busy cycles + 1 READY cycle minimum.
- The pointer is 10 bits. Only bits [8:0] address the store when ptr<512.

## Configuration
- **SD_RESP_CRC_EN defined:** during a write block, a CRC-16-CCITT is accumulated over bytes 0..511.
  - Polynomial 0x1021, init 0x0000, MSB first.
  - Bytes 512 and 513 are compared to the CRC as {high, low}.
  - On mismatch, crc_err=1 from the completion of byte 513 until the next OPEN or INIT.
- **SD_RESP_CRC_EN undefined:** crc_err is constant 0 and there is no CRC logic.

## Test plan
- **Init:** pulse rst_req 1 cycle → busy high exactly 16 cycles, then low. err=0.
- **Write then read back:**
  - Write block 32'h0010_0001 with bytes AA,BB,CC,DD followed by 508 zeros.
  - Read the same block with 4 r_byte requests → data_out sequence AA,BB,CC,DD. data_out=FF right after OPEN.
- **Out of range:** r_block with block_addr=32'h0010_0004 → err=1 after OPEN, every byte reads FF. A later valid open → err=0.
- **Overrun:**
  - Write 515 bytes. The 513th–515th bytes do not alter the store; verify via read-back of bytes 0 and 511.
  - Reading past 512 returns FF.
- **Abort:** assert rst_req during WR_BYTE at byte 100 → next cycle in INIT, busy stays high 16 cycles. Bytes 0..99 are retained.
- **CRC (SD_RESP_CRC_EN):**
  - 512 bytes of 8'h00 followed by CRC bytes 00,00 → crc_err=0.
  - The same data with trailer 12,34 → crc_err=1 after byte 513, cleared by the next OPEN.

Source files
------------

// File: rtl/sd_block_responder.sv
// sd_block_responder
// Loopback stand-in for an SD card behind the SPI host byte handshake. It
// answers card-init, block-read/write and byte-read/write requests with busy
// handshakes and serves bytes from an internal NUM_BLOCKS x 512 byte store.
//
// Ports:
//   clk         clock
//   rst         synchronous, active-high reset
//   rst_req     card init request (level)
//   block_addr  card block address, sampled when a block is opened
//   r_block     read-block request, held for the whole block
//   r_byte      next-byte read request (level)
//   w_block     write-block request, held for the whole block
//   w_byte      next-byte write request (level)
//   data_in     write byte, sampled on the last busy cycle of a byte write
//   data_out    last byte read (8'hFF after open / for invalid reads)
//   busy        operation in progress
//   err         address or sequence error
//   crc_err     write CRC mismatch
//
// Build option:
//   SD_RESP_CRC_EN  when defined, a CRC-16-CCITT (poly 0x1021, init 0, MSB
//                   first) is accumulated over write bytes 0..511 and compared
//                   with bytes 512/513; otherwise crc_err is tied to 0.
//
// BYTE_LAT must be at least 2: the store read is registered and the byte is
// taken from the read register on the last busy cycle.

module sd_block_responder #(
    parameter int unsigned NUM_BLOCKS  = 4,
    parameter logic [31:0] BASE_ADDR   = 32'h0010_0000,
    parameter int unsigned INIT_CYCLES = 16,
    parameter int unsigned BLOCK_LAT   = 8,
    parameter int unsigned BYTE_LAT    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rst_req,
    input  logic [31:0] block_addr,
    input  logic        r_block,
    input  logic        r_byte,
    input  logic        w_block,
    input  logic        w_byte,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic        busy,
    output logic        err,
    output logic        crc_err
);

    localparam int unsigned DEPTH = NUM_BLOCKS * 512;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned IW    = (AW > 9) ? AW - 9 : 1;

    localparam logic [15:0] INIT_LAST  = 16'(INIT_CYCLES - 1);
    localparam logic [15:0] BLOCK_LAST = 16'(BLOCK_LAT - 1);
    localparam logic [15:0] BYTE_LAST  = 16'(BYTE_LAT - 1);

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        OPEN,
        RD_READY,
        RD_BYTE,
        WR_READY,
        WR_BYTE
    } state_t;

    state_t state, state_next;

    logic [15:0]   cnt;
    logic          initialized;
    logic          dir_rd;
    logic          in_range;
    logic [IW-1:0] idx_q;
    logic [9:0]    ptr;
    logic [9:0]    ptr_inc;
    logic [31:0]   idx_full;
    logic          open_in_range;

    logic          open_req;
    logic          open_done;
    logic          init_done;
    logic          seq_err;
    logic          rd_done;
    logic          wr_done;

    logic [7:0]    mem [0:DEPTH-1];
    logic [7:0]    rd_data;
    logic [AW-1:0] mem_addr;
    logic          mem_we;

    // Block index uses 32-bit wrap, so addresses below BASE_ADDR land far out
    // of range rather than aliasing onto low blocks.
    assign idx_full      = block_addr - BASE_ADDR;
    assign open_in_range = idx_full < 32'(NUM_BLOCKS);

    assign ptr_inc  = (ptr == 10'h3FF) ? ptr : ptr + 10'd1;
    assign mem_addr = AW'({idx_q, ptr[8:0]});
    assign mem_we   = wr_done && in_range && !ptr[9];

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Latency counter restarts on every state change and only runs while busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (state_next != state) begin
            cnt <= '0;
        end else if (busy) begin
            cnt <= cnt + 16'd1;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state and control strobes
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        open_req   = 1'b0;
        open_done  = 1'b0;
        init_done  = 1'b0;
        seq_err    = 1'b0;
        rd_done    = 1'b0;
        wr_done    = 1'b0;

        case (state)
            IDLE: begin
                if (rst_req) begin
                    state_next = INIT;
                end else if (r_block || w_block) begin
                    if (initialized) begin
                        state_next = OPEN;
                        open_req   = 1'b1;
                    end else begin
                        seq_err = 1'b1;
                    end
                end
            end

            INIT: begin
                busy = 1'b1;
                if (cnt == INIT_LAST) begin
                    state_next = IDLE;
                    init_done  = 1'b1;
                end
            end

            OPEN: begin
                busy = 1'b1;
                if (rst_req) begin
                    state_next = INIT;
                end else if (cnt == BLOCK_LAST) begin
                    state_next = dir_rd ? RD_READY : WR_READY;
                    open_done  = 1'b1;
                end
            end

            RD_READY: begin
                if (rst_req) begin
                    state_next = INIT;
                end else if (!r_block) begin
                    state_next = IDLE;
                end else begin
                    if (r_byte) begin
                        state_next = RD_BYTE;
                    end
                    if (w_byte) begin
                        seq_err = 1'b1;
                    end
                end
            end

            RD_BYTE: begin
                busy = 1'b1;
                if (rst_req) begin
                    state_next = INIT;
                end else if (cnt == BYTE_LAST) begin
                    state_next = RD_READY;
                    rd_done    = 1'b1;
                end
            end

            WR_READY: begin
                if (rst_req) begin
                    state_next = INIT;
                end else if (!w_block) begin
                    state_next = IDLE;
                end else begin
                    if (w_byte) begin
                        state_next = WR_BYTE;
                    end
                    if (r_byte) begin
                        seq_err = 1'b1;
                    end
                end
            end

            WR_BYTE: begin
                busy = 1'b1;
                if (rst_req) begin
                    state_next = INIT;
                end else if (cnt == BYTE_LAST) begin
                    state_next = WR_READY;
                    wr_done    = 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Block context, pointer, flags and read data
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            initialized <= 1'b0;
            err         <= 1'b0;
            data_out    <= 8'hFF;
            dir_rd      <= 1'b0;
            in_range    <= 1'b0;
            idx_q       <= '0;
            ptr         <= '0;
        end else begin
            if (init_done) begin
                initialized <= 1'b1;
                err         <= 1'b0;
            end

            if (open_req) begin
                dir_rd   <= r_block;
                in_range <= open_in_range;
                idx_q    <= idx_full[IW-1:0];
                ptr      <= '0;
                data_out <= 8'hFF;
            end

            if (open_done) begin
                err <= !in_range;
            end

            if (seq_err) begin
                err <= 1'b1;
            end

            if (rd_done) begin
                data_out <= (in_range && !ptr[9]) ? rd_data : 8'hFF;
                ptr      <= ptr_inc;
            end

            if (wr_done) begin
                ptr <= ptr_inc;
            end
        end
    end

    // Store: registered read every cycle; the pointer is stable for the whole
    // byte, so rd_data is valid by the last busy cycle when BYTE_LAT >= 2.
    always_ff @(posedge clk) begin
        rd_data <= mem[mem_addr];
        if (mem_we) begin
            mem[mem_addr] <= data_in;
        end
    end

    // ------------------------------------------------------------------
    // Optional write CRC check
    // ------------------------------------------------------------------
`ifdef SD_RESP_CRC_EN
    logic [15:0] crc;
    logic [7:0]  crc_hi;
    logic        crc_err_q;

    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c ^ {d, 8'h00};
        for (int unsigned i = 0; i < 8; i++) begin
            r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            crc       <= '0;
            crc_hi    <= '0;
            crc_err_q <= 1'b0;
        end else if (open_req || init_done) begin
            crc       <= '0;
            crc_hi    <= '0;
            crc_err_q <= 1'b0;
        end else if (wr_done) begin
            if (!ptr[9]) begin
                crc <= crc16_byte(crc, data_in);
            end else if (ptr == 10'd512) begin
                crc_hi <= data_in;
            end else if (ptr == 10'd513 && {crc_hi, data_in} != crc) begin
                crc_err_q <= 1'b1;
            end
        end
    end

    assign crc_err = crc_err_q;
`else
    assign crc_err = 1'b0;
`endif

endmodule
